// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO between instruction fetch and dual-issue decode.
// Accepts one {pc, instr} per cycle, exposes the two oldest entries.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     in_ready,
    output logic                     dec_valid0,
    output logic [XLEN-1:0]          dec_pc0,
    output logic [XLEN-1:0]          dec_instr0,
    output logic                     dec_valid1,
    output logic [XLEN-1:0]          dec_pc1,
    output logic [XLEN-1:0]          dec_instr1,
    input  logic [1:0]               dec_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic [CW-1:0] take_w;
    logic [CW-1:0] pop_w;
    logic [AW-1:0] head_nxt1;

    // Readiness looks only at registered occupancy: a full queue never
    // accepts, even if decode drains in the same cycle.
    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready && !flush;

    always_comb begin
        take_w = '0;
        pop_w  = '0;
        take_w = dec_take[1] ? CW'(2) : CW'(dec_take);
        pop_w  = (count_q < take_w) ? count_q : take_w;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_w);
            tail_d  = tail_q + AW'(push);
            count_d = count_q + CW'(push) - pop_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is intentionally left uninitialised; valid gating hides it.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[tail_q]    <= in_pc;
            instr_mem[tail_q] <= in_instr;
        end
    end

    assign head_nxt1 = head_q + AW'(1);

    always_comb begin
        dec_valid0 = (count_q != '0);
        dec_valid1 = (count_q >= CW'(2));
        dec_pc0    = '0;
        dec_instr0 = '0;
        dec_pc1    = '0;
        dec_instr1 = '0;
        if (dec_valid0) begin
            dec_pc0    = pc_mem[head_q];
            dec_instr0 = instr_mem[head_q];
        end
        if (dec_valid1) begin
            dec_pc1    = pc_mem[head_nxt1];
            dec_instr1 = instr_mem[head_nxt1];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic             clk = 0;
    logic             reset = 0;
    logic             flush = 0;
    logic             in_valid = 0;
    logic [XLEN-1:0]  in_pc = '0;
    logic [XLEN-1:0]  in_instr = '0;
    logic             in_ready;
    logic             dec_valid0;
    logic [XLEN-1:0]  dec_pc0;
    logic [XLEN-1:0]  dec_instr0;
    logic             dec_valid1;
    logic [XLEN-1:0]  dec_pc1;
    logic [XLEN-1:0]  dec_instr1;
    logic [1:0]       dec_take = '0;
    logic [3:0]       count;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_ready(in_ready),
        .dec_valid0(dec_valid0), .dec_pc0(dec_pc0), .dec_instr0(dec_instr0),
        .dec_valid1(dec_valid1), .dec_pc1(dec_pc1), .dec_instr1(dec_instr1),
        .dec_take(dec_take), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] mdl_q[$];
    bit          mdl_ok = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [63:0] e0;
        logic [63:0] e1;
        int n;
        n  = mdl_q.size();
        e0 = (n >= 1) ? mdl_q[0] : 64'd0;
        e1 = (n >= 2) ? mdl_q[1] : 64'd0;
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
        chk("valid0", 64'(dec_valid0), 64'(n >= 1));
        chk("valid1", 64'(dec_valid1), 64'(n >= 2));
        chk("slot0", {dec_pc0, dec_instr0}, e0);
        chk("slot1", {dec_pc1, dec_instr1}, e1);
    endtask

    task automatic model_update(input bit rst, input bit fl, input bit v,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic [1:0] tk);
        int take;
        int pop;
        bit acc;
        if (rst || fl) begin
            mdl_q.delete();
        end else begin
            acc  = v && (mdl_q.size() != DEPTH);
            take = (tk == 2'd3) ? 2 : int'(tk);
            pop  = (take < mdl_q.size()) ? take : mdl_q.size();
            repeat (pop) void'(mdl_q.pop_front());
            if (acc) mdl_q.push_back({p, i});
        end
        if (rst) mdl_ok = 1;
    endtask

    // Called at a falling edge: check, drive, advance one cycle.
    task automatic step(input bit rst, input bit fl, input bit v,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic [1:0] tk);
        if (mdl_ok) compare_all();
        reset    = rst;
        flush    = fl;
        in_valid = v;
        in_pc    = p;
        in_instr = i;
        dec_take = tk;
        @(posedge clk);
        model_update(rst, fl, v, p, i, tk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_ready", 64'(in_ready), 1);
        chk("rst_v0", 64'(dec_valid0), 0);
        chk("rst_v1", 64'(dec_valid1), 0);
        chk("rst_pc0", 64'(dec_pc0), 0);

        step(0, 0, 1, 32'h0, 32'h0050_0093, 0);
        chk("one_v0", 64'(dec_valid0), 1);
        chk("one_instr0", 64'(dec_instr0), 64'h0050_0093);
        chk("one_v1", 64'(dec_valid1), 0);
        chk("one_count", 64'(count), 1);

        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            step(0, 0, 1, 32'(4 * k), 32'h1000 + 32'(k), 0);
        chk("full_count", 64'(count), 8);
        chk("full_ready", 64'(in_ready), 0);
        step(0, 0, 1, 32'h20, 32'h2020, 2);
        chk("refuse_count", 64'(count), 6);
        chk("refuse_ready", 64'(in_ready), 1);
        chk("refuse_pc0", 64'(dec_pc0), 64'h8);

        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++)
            step(0, 0, 1, 32'(4 * k), 32'h3000 + 32'(k), 0);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h40, 32'h4040, 0);
        step(0, 0, 1, 32'h44, 32'h4044, 0);
        step(0, 0, 1, 32'h48, 32'h4048, 0);
        chk("wrap_pc0", 64'(dec_pc0), 64'h40);
        chk("wrap_pc1", 64'(dec_pc1), 64'h44);
        step(0, 0, 0, 0, 0, 2);
        chk("wrap2_pc0", 64'(dec_pc0), 64'h48);
        chk("wrap2_v1", 64'(dec_valid1), 0);
        chk("wrap2_count", 64'(count), 1);

        step(0, 0, 1, 32'h80, 32'h8080, 2);
        chk("ovt_count", 64'(count), 1);
        chk("ovt_pc0", 64'(dec_pc0), 64'h80);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        chk("empty_count", 64'(count), 0);

        for (int k = 0; k < 5; k++)
            step(0, 0, 1, 32'h200 + 32'(4 * k), 32'(k), 0);
        chk("pre_flush", 64'(count), 5);
        step(0, 1, 1, 32'h300, 32'h300, 1);
        chk("fl_count", 64'(count), 0);
        chk("fl_v0", 64'(dec_valid0), 0);
        chk("fl_ready", 64'(in_ready), 1);
        step(0, 0, 1, 32'h100, 32'h0100_0113, 0);
        chk("fl_push_v0", 64'(dec_valid0), 1);
        chk("fl_push_pc0", 64'(dec_pc0), 64'h100);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom, $urandom,
                 2'($urandom_range(0, 3)));
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer side of the fetch interface. Accepts one fetched {PC, instruction} pair per cycle from the PC/instruction-fetch stage and buffers it in a circular FIFO.
- Presents the two oldest entries to the dual-issue decode stage, which retires 0, 1 or 2 entries per cycle.
- Back-pressures fetch when full. Discards all contents on a control-flow redirect (flush).

Parameters:
- DEPTH, 8, number of entries. Power of two, DEPTH >= 4.
- XLEN, 32, width of the PC and instruction fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- flush  input  1  redirect/mispredict; empties the queue.
- in_valid  input  1  fetch presents a valid entry.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- in_ready  output  1  queue can accept an entry this cycle.
- dec_valid0  output  1  slot 0 (oldest entry) valid.
- dec_pc0  output  XLEN  slot 0 PC.
- dec_instr0  output  XLEN  slot 0 instruction.
- dec_valid1  output  1  slot 1 (second-oldest entry) valid.
- dec_pc1  output  XLEN  slot 1 PC.
- dec_instr1  output  XLEN  slot 1 instruction.
- dec_take  input  2  number of entries decode consumes this cycle (0, 1 or 2; 3 is treated as 2).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array of DEPTH x {pc, instr}, plus head pointer, tail pointer and count.
- Both pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Reset (synchronous, highest priority): head=0, tail=0, count=0. After reset, in_ready=1, dec_valid0=0, dec_valid1=0, and all dec_pc*/dec_instr*=0. Storage contents are not cleared.
- in_ready = (count != DEPTH). It is computed from the registered count only; there is no same-cycle pop-to-push bypass, so a full queue refuses a push even when decode pops that cycle.
- Push: accepted when in_valid && in_ready && !flush. The entry is written at tail and tail increments.
- Effective pop: pop = min(dec_take clamped to 2, count). head advances by pop. Over-take beyond the available entries is silently clamped and is never an error.
- Count update: count_next = count + push - pop. Simultaneous push and pop are both honoured.
- Flush (when not in reset): head=0, tail=0, count=0. The concurrent push and pop are both discarded. From the next cycle in_ready=1 and both valids are 0.
- Output slots are combinational reads from registered state:
  - slot 0 reads storage[head] and dec_valid0 = (count >= 1).
  - slot 1 reads storage[head+1 mod DEPTH] and dec_valid1 = (count >= 2).
  - A slot whose valid is 0 drives its pc and instr as 0.
- Latency: an entry pushed in cycle N is first visible at the slot outputs in cycle N+1. There is no empty-queue bypass.
- Ordering is strict FIFO. Slot 1 is never valid while slot 0 is invalid.
- Wrap-around: when head = DEPTH-1, slot 1 reads entry 0.
- Outputs must never be X after reset, regardless of storage contents.

Test Plan:
- Reset then idle: assert reset 2 cycles, in_valid=0 -> count=0, in_ready=1, dec_valid0/1=0, dec_pc0=0.
- Single push: push pc=0x00000000 instr=0x00500093 at cycle N, dec_take=0 -> at cycle N+1 dec_valid0=1, dec_pc0=0x0, dec_instr0=0x00500093, dec_valid1=0, count=1.
- Fill and back-pressure, DEPTH=8:
  - Push PCs 0x0, 0x4, ..., 0x1C with dec_take=0 -> count=8, in_ready=0.
  - A 9th push with dec_take=2 in the same cycle -> the push is refused and count goes to 6; the next cycle in_ready=1.
- Dual pop with wrap-around: drive the queue so head=7 with 3 entries (PCs 0x40, 0x44, 0x48) -> dec_pc0=0x40, dec_pc1=0x44. With dec_take=2, the next cycle gives dec_pc0=0x48, dec_valid1=0, count=1.
- Over-take and concurrent push/pop:
  - count=1, dec_take=2, with a push of pc=0x80 -> the next cycle count=1 and dec_pc0=0x80.
  - count=0, dec_take=2 -> count stays 0 with no underflow.
- Flush: with count=5, assert flush together with in_valid=1 and dec_take=1 -> the next cycle count=0, dec_valid0=0, in_ready=1. A push of pc=0x100 the following cycle appears at slot 0 one cycle later.
